// File: rtl/std_cache_pkg.sv
// Shared types for the L1 data-cache flush sequencer: walk states, writeback
// request payload and the saturating dirty-line counter helper.
package std_cache_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned PADDR_WIDTH       = 56;
  localparam int unsigned DIRTY_CNT_WIDTH   = 16;

  typedef enum logic [2:0] {
    FLUSH_IDLE,
    FLUSH_READ,
    FLUSH_CHECK,
    FLUSH_WB_REQ,
    FLUSH_WB_WAIT,
    FLUSH_INV,
    FLUSH_ADV,
    FLUSH_DONE
  } flush_state_e;

  typedef struct packed {
    logic [PADDR_WIDTH-1:0]       addr;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } wb_req_t;

  // Counter sticks at all-ones rather than wrapping.
  function automatic logic [DIRTY_CNT_WIDTH-1:0] sat_inc(input logic [DIRTY_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_flush_seq.sv
// Flush sequencer: visits every (set, way), writes back valid+dirty lines and
// invalidates every valid line through one arbiter requester port.
module dcache_flush_seq
  import std_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 256,
  parameter int unsigned SET_ASSOC   = 8,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned TAG_WIDTH   = 44,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned BYTE_OFFSET = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  output logic                              flush_ack_o,
  output logic                              busy_o,
  output logic [SET_ASSOC-1:0]              req_o,
  output logic [INDEX_WIDTH-1:0]            addr_o,
  output logic                              we_o,
  input  logic                              gnt_i,
  input  logic                              rd_valid_i,
  input  logic                              rd_dirty_i,
  input  logic [TAG_WIDTH-1:0]              rd_tag_i,
  input  logic [LINE_WIDTH-1:0]             rd_data_i,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [PADDR_WIDTH-1:0]            wb_addr_o,
  output logic [LINE_WIDTH-1:0]             wb_data_o,
  input  logic                              wb_done_i,
  output logic [DIRTY_CNT_WIDTH-1:0]        dirty_cnt_o
);

  localparam int unsigned SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int unsigned WAY_W = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1;

  flush_state_e                state_q;
  logic [SET_W-1:0]            set_q;
  logic [SET_W-1:0]            set_d;
  logic [WAY_W-1:0]            way_q;
  logic [WAY_W-1:0]            way_d;
  logic [SET_ASSOC-1:0]        req_q;
  logic                        we_q;
  logic [INDEX_WIDTH-1:0]      addr_q;
  logic                        wb_valid_q;
  logic                        ack_q;
  logic                        busy_q;
  wb_req_t                     wb_q;
  logic [DIRTY_CNT_WIDTH-1:0]  dirty_cnt_q;
  logic                        last_way;
  logic                        last_set;

  // Set number placed in the index field above the byte offset, upper bits zero.
  function automatic logic [INDEX_WIDTH-1:0] set_index(input logic [SET_W-1:0] s);
    logic [INDEX_WIDTH-1:0] idx;
    idx = '0;
    idx[BYTE_OFFSET +: SET_W] = s;
    return idx;
  endfunction

  function automatic logic [SET_ASSOC-1:0] way_onehot(input logic [WAY_W-1:0] w);
    logic [SET_ASSOC-1:0] oh;
    oh    = '0;
    oh[w] = 1'b1;
    return oh;
  endfunction

  assign last_way = (way_q == WAY_W'(SET_ASSOC - 1));
  assign last_set = (set_q == SET_W'(NUM_SETS - 1));
  assign way_d    = last_way ? '0 : way_q + 1'b1;
  assign set_d    = last_way ? set_q + 1'b1 : set_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FLUSH_IDLE;
      set_q       <= '0;
      way_q       <= '0;
      req_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wb_valid_q  <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      wb_q        <= '0;
      dirty_cnt_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        FLUSH_IDLE: begin
          if (flush_i) begin
            set_q       <= '0;
            way_q       <= '0;
            dirty_cnt_q <= '0;
            req_q       <= way_onehot(WAY_W'(0));
            we_q        <= 1'b0;
            addr_q      <= set_index(SET_W'(0));
            busy_q      <= 1'b1;
            state_q     <= FLUSH_READ;
          end
        end
        FLUSH_READ: begin
          if (gnt_i) begin
            req_q   <= '0;
            addr_q  <= '0;
            state_q <= FLUSH_CHECK;
          end
        end
        FLUSH_CHECK: begin
          // Read data arrives the cycle after the grant, so it is captured here.
          wb_q.addr <= {rd_tag_i, set_index(set_q)};
          wb_q.data <= rd_data_i;
          if (rd_valid_i && rd_dirty_i) begin
            wb_valid_q <= 1'b1;
            state_q    <= FLUSH_WB_REQ;
          end else if (rd_valid_i) begin
            req_q   <= way_onehot(way_q);
            we_q    <= 1'b1;
            addr_q  <= set_index(set_q);
            state_q <= FLUSH_INV;
          end else begin
            state_q <= FLUSH_ADV;
          end
        end
        FLUSH_WB_REQ: begin
          if (wb_ready_i) begin
            wb_valid_q  <= 1'b0;
            dirty_cnt_q <= sat_inc(dirty_cnt_q);
            state_q     <= FLUSH_WB_WAIT;
          end
        end
        FLUSH_WB_WAIT: begin
          if (wb_done_i) begin
            req_q   <= way_onehot(way_q);
            we_q    <= 1'b1;
            addr_q  <= set_index(set_q);
            state_q <= FLUSH_INV;
          end
        end
        FLUSH_INV: begin
          if (gnt_i) begin
            req_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            state_q <= FLUSH_ADV;
          end
        end
        FLUSH_ADV: begin
          if (last_way && last_set) begin
            ack_q   <= 1'b1;
            state_q <= FLUSH_DONE;
          end else begin
            way_q   <= way_d;
            set_q   <= set_d;
            req_q   <= way_onehot(way_d);
            we_q    <= 1'b0;
            addr_q  <= set_index(set_d);
            state_q <= FLUSH_READ;
          end
        end
        FLUSH_DONE: begin
          busy_q  <= 1'b0;
          state_q <= FLUSH_IDLE;
        end
        default: begin
          state_q <= FLUSH_IDLE;
        end
      endcase
    end
  end

  assign flush_ack_o = ack_q;
  assign busy_o      = busy_q;
  assign req_o       = req_q;
  assign addr_o      = addr_q;
  assign we_o        = we_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_addr_o   = wb_q.addr;
  assign wb_data_o   = wb_q.data;
  assign dirty_cnt_o = dirty_cnt_q;

endmodule

// File: tb/tb_dcache_flush_seq.sv
// Scoreboard bench for the flush sequencer on a 4-set, 2-way cache image:
// stimulus queues expected accesses/writebacks/acks, a monitor pops and compares.
module tb_dcache_flush_seq;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          flush_ack_o;
  logic          busy_o;
  logic [1:0]    req_o;
  logic [11:0]   addr_o;
  logic          we_o;
  logic          gnt_i;
  logic          rd_valid_i;
  logic          rd_dirty_i;
  logic [43:0]   rd_tag_i;
  logic [127:0]  rd_data_i;
  logic          wb_valid_o;
  logic          wb_ready_i;
  logic [55:0]   wb_addr_o;
  logic [127:0]  wb_data_o;
  logic          wb_done_i;
  logic [15:0]   dirty_cnt_o;

  dcache_flush_seq #(
    .NUM_SETS(4), .SET_ASSOC(2), .LINE_WIDTH(128),
    .TAG_WIDTH(44), .INDEX_WIDTH(12), .BYTE_OFFSET(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .busy_o(busy_o), .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .gnt_i(gnt_i),
    .rd_valid_i(rd_valid_i), .rd_dirty_i(rd_dirty_i), .rd_tag_i(rd_tag_i),
    .rd_data_i(rd_data_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_done_i(wb_done_i),
    .dirty_cnt_o(dirty_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Cache image seen by the arbiter model.
  logic          mem_v    [4][2];
  logic          mem_d    [4][2];
  logic [43:0]   mem_tag  [4][2];
  logic [127:0]  mem_data [4][2];

  logic [14:0]   exp_acc [$];   // {we, req, addr}
  logic [183:0]  exp_wb  [$];   // {addr, data}
  logic [15:0]   exp_ack [$];   // dirty count at ack

  int checks = 0;
  int errors = 0;
  int stall_cfg = 0, stall_left = 0;
  int ready_cfg = 0, ready_left = 0;
  int done_cnt = 0;
  logic [55:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;

  function automatic void check(input string name, input logic [183:0] act, input logic [183:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  task automatic clear_image();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        mem_v[s][w] = 1'b0; mem_d[s][w] = 1'b0;
        mem_tag[s][w] = '0; mem_data[s][w] = '0;
      end
  endtask

  // Expected transaction stream for the current image, in walk order.
  task automatic push_walk();
    logic [15:0] cnt;
    logic [1:0]  oh;
    logic [11:0] idx;
    cnt = '0;
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        oh  = 2'b01 << w;
        idx = 12'(s * 16);
        exp_acc.push_back({1'b0, oh, idx});
        if (mem_v[s][w]) begin
          if (mem_d[s][w]) begin
            exp_wb.push_back({mem_tag[s][w], idx, mem_data[s][w]});
            cnt++;
          end
          exp_acc.push_back({1'b1, oh, idx});
        end
      end
    exp_ack.push_back(cnt);
  endtask

  task automatic do_flush(input int drop_after, output int cycles);
    bit seen;
    push_walk();
    @(negedge clk_i);
    flush_i = 1'b1;
    cycles  = 0;
    seen    = 1'b0;
    while (!seen && cycles < 3000) begin
      @(posedge clk_i);
      cycles++;
      #1;
      if (cycles == 1) check("busy_in_walk", busy_o, 1'b1);
      if (drop_after > 0 && cycles == drop_after) flush_i = 1'b0;
      if (flush_ack_o) seen = 1'b1;
    end
    flush_i = 1'b0;
    if (!seen) begin
      errors++; checks++;
      $display("FAIL ack_timeout: got no flush_ack_o required ack within 3000 cycles");
    end
    @(posedge clk_i); #1;
    check("busy_idle", busy_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check("acc_drained", exp_acc.size(), 0);
    check("wb_drained", exp_wb.size(), 0);
    check("ack_drained", exp_ack.size(), 0);
  endtask

  // Arbiter and miss-handler model, driving on the falling edge.
  initial begin
    int s, w;
    gnt_i = 1'b0; wb_ready_i = 1'b0; wb_done_i = 1'b0;
    rd_valid_i = 1'b0; rd_dirty_i = 1'b0; rd_tag_i = '0; rd_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        gnt_i = 1'b0; wb_ready_i = 1'b0; wb_done_i = 1'b0; done_cnt = 0;
      end else begin
        wb_done_i = 1'b0;
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) wb_done_i = 1'b1;
        end
        if (req_o != 2'b00) begin
          if (stall_left > 0) begin
            gnt_i = 1'b0;
            stall_left--;
          end else begin
            gnt_i = 1'b1;
            stall_left = stall_cfg;
            s = int'(addr_o[5:4]);
            w = req_o[1] ? 1 : 0;
            if (we_o) begin
              mem_v[s][w] = 1'b0;
              mem_d[s][w] = 1'b0;
            end else begin
              rd_valid_i = mem_v[s][w];
              rd_dirty_i = mem_d[s][w];
              rd_tag_i   = mem_tag[s][w];
              rd_data_i  = mem_data[s][w];
            end
          end
        end else begin
          gnt_i = 1'b0;
        end
        if (wb_valid_o) begin
          if (ready_left > 0) begin
            wb_ready_i = 1'b0;
            ready_left--;
          end else begin
            wb_ready_i = 1'b1;
            ready_left = ready_cfg;
            done_cnt   = 3;
          end
        end else begin
          wb_ready_i = 1'b0;
        end
      end
    end
  end

  // Monitor: samples mid-low-phase, after the model has driven its inputs.
  initial begin
    logic [1:0]   prev_req;
    logic         prev_we, prev_gnt, prev_wbv, prev_rdy, prev_ack;
    logic [11:0]  prev_addr;
    logic [183:0] prev_wb;
    prev_req = '0; prev_we = 0; prev_gnt = 0; prev_wbv = 0; prev_rdy = 0;
    prev_ack = 0; prev_addr = '0; prev_wb = '0;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        prev_req = '0; prev_gnt = 0; prev_wbv = 0; prev_rdy = 0; prev_ack = 0;
      end else begin
        if (prev_req != 2'b00 && !prev_gnt)
          check("req_stable", {req_o, we_o, addr_o}, {prev_req, prev_we, prev_addr});
        if (prev_wbv && !prev_rdy)
          check("wb_stable", {wb_valid_o, wb_addr_o, wb_data_o}, {1'b1, prev_wb});
        if (req_o != 2'b00 && gnt_i) begin
          if (exp_acc.size() == 0) begin
            checks++; errors++;
            $display("FAIL access: got %0h required no access", {we_o, req_o, addr_o});
          end else check("access", {we_o, req_o, addr_o}, exp_acc.pop_front());
        end
        if (wb_valid_o && wb_ready_i) begin
          last_wb_addr = wb_addr_o;
          last_wb_data = wb_data_o;
          if (exp_wb.size() == 0) begin
            checks++; errors++;
            $display("FAIL writeback: got %0h required no writeback", wb_addr_o);
          end else check("writeback", {wb_addr_o, wb_data_o}, exp_wb.pop_front());
        end
        if (flush_ack_o) begin
          check("ack_one_cycle", prev_ack, 1'b0);
          if (exp_ack.size() == 0) begin
            checks++; errors++;
            $display("FAIL ack: got flush_ack_o required none");
          end else check("ack_dirty_cnt", dirty_cnt_o, exp_ack.pop_front());
        end
        prev_req = req_o; prev_we = we_o; prev_addr = addr_o; prev_gnt = gnt_i;
        prev_wbv = wb_valid_o; prev_rdy = wb_ready_i; prev_wb = {wb_addr_o, wb_data_o};
        prev_ack = flush_ack_o;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {req_o, we_o, addr_o, wb_valid_o, wb_addr_o, busy_o, flush_ack_o, dirty_cnt_o}, '0);
    check({name, "_wb_data"}, wb_data_o, '0);
  endtask

  initial begin
    int  cyc;
    bit  found;
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    clear_image();
    #3;
    check_all_zero("reset_state");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // All lines invalid: 8 reads, 3 cycles each, ack on the 25th edge.
    do_flush(0, cyc);
    check("latency_all_invalid", cyc, 25);
    check("dirty_cnt_zero", dirty_cnt_o, 16'd0);

    // One dirty line at set 2 way 1.
    clear_image();
    mem_v[2][1] = 1'b1; mem_d[2][1] = 1'b1;
    mem_tag[2][1] = 44'h1234; mem_data[2][1] = {16{8'hA5}};
    do_flush(0, cyc);
    check("wb_addr_hand", last_wb_addr, 56'h0000_0001_2340_20);
    check("wb_data_hand", last_wb_data, {16{8'hA5}});
    check("dirty_cnt_one", dirty_cnt_o, 16'd1);
    check("line_invalidated", {mem_v[2][1], mem_d[2][1]}, 2'b00);

    // Valid clean line: invalidate only.
    clear_image();
    mem_v[0][0] = 1'b1; mem_tag[0][0] = 44'h77;
    do_flush(0, cyc);
    check("clean_dirty_cnt", dirty_cnt_o, 16'd0);
    check("clean_invalidated", mem_v[0][0], 1'b0);

    // Slow grants and slow writeback acceptance.
    clear_image();
    mem_v[1][1] = 1'b1; mem_d[1][1] = 1'b1;
    mem_tag[1][1] = 44'hABC; mem_data[1][1] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    mem_v[3][0] = 1'b1; mem_tag[3][0] = 44'h5;
    stall_cfg = 5; stall_left = 5; ready_cfg = 3; ready_left = 3;
    do_flush(0, cyc);
    check("stall_dirty_cnt", dirty_cnt_o, 16'd1);
    check("stall_wb_addr", last_wb_addr, 56'h0000_0000_0ABC_01 << 4);
    stall_cfg = 0; stall_left = 0; ready_cfg = 0; ready_left = 0;

    // flush_i dropped two cycles into the walk.
    clear_image();
    mem_v[3][1] = 1'b1; mem_d[3][1] = 1'b1;
    mem_tag[3][1] = 44'hF00D; mem_data[3][1] = {4{32'hDEAD_BEEF}};
    do_flush(2, cyc);
    check("drop_dirty_cnt", dirty_cnt_o, 16'd1);
    repeat (10) @(posedge clk_i);
    #1;
    check("drop_no_restart", busy_o, 1'b0);

    // Reset while waiting for the writeback response.
    clear_image();
    mem_v[1][0] = 1'b1; mem_d[1][0] = 1'b1;
    mem_tag[1][0] = 44'h42; mem_data[1][0] = {8{16'h1357}};
    push_walk();
    @(negedge clk_i);
    flush_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk_i);
      #3;
      if (done_cnt == 2 && !wb_valid_o) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL reach_wb_wait: got no writeback handshake required one within 500 cycles");
    end
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_acc.delete(); exp_wb.delete(); exp_ack.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    do_flush(0, cyc);
    check("restart_dirty_cnt", dirty_cnt_o, 16'd1);
    check("restart_wb_addr", last_wb_addr, 56'h0000_0000_0042_01 << 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion required finish before 300000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_flush_seq.md
Name: dcache_flush_seq

Overview:
Sequencer that walks every set and way of the L1 data-cache arrays on a flush request. It writes back valid+dirty lines to memory and invalidates every valid line. It is one requester port of the SRAM tag-compare/arbiter (read/write valid, dirty, tag and data of one way per access). Writebacks go through a valid/ready + done handshake into the miss-handler AXI write path.

Parameters:
NUM_SETS, 256, number of cache sets (index rows per SRAM)
SET_ASSOC, 8, number of ways
LINE_WIDTH, 128, data bits per line
TAG_WIDTH, 44, tag bits per line
INDEX_WIDTH, 12, byte-address index width; set = addr[INDEX_WIDTH-1:BYTE_OFFSET]
BYTE_OFFSET, 4, log2(LINE_WIDTH/8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  flush request, level, held until flush_ack_o
flush_ack_o  out  1  one-cycle pulse when the walk completes
busy_o  out  1  high in every state except IDLE
req_o  out  SET_ASSOC  one-hot way select to the arbiter
addr_o  out  INDEX_WIDTH  {set, BYTE_OFFSET zeros}
we_o  out  1  write (invalidate) when high
gnt_i  in  1  arbiter grant for the current access
rd_valid_i  in  1  valid bit of the requested way, one cycle after grant
rd_dirty_i  in  1  dirty bit, same timing
rd_tag_i  in  TAG_WIDTH  tag, same timing
rd_data_i  in  LINE_WIDTH  line data, same timing
wb_valid_o  out  1  writeback request
wb_ready_i  in  1  writeback accepted
wb_addr_o  out  56  {tag, set, BYTE_OFFSET zeros} physical line address
wb_data_o  out  LINE_WIDTH  line to write
wb_done_i  in  1  writeback B-response received, one-cycle pulse
dirty_cnt_o  out  16  dirty lines written back in the current/last flush, saturating

Behaviour:
- Reset (async): state IDLE; set_q=0; way_q=0; dirty_cnt=0; all outputs 0.
- IDLE: all request outputs 0. On flush_i=1: set_q=0, way_q=0, dirty_cnt=0, go to READ.
- READ:
  - req_o=1<<way_q, we_o=0, addr_o={set_q,0}. Hold until gnt_i.
  - On gnt_i, go to CHECK next cycle; rd_* are sampled there.
  - req_o drops the cycle after the grant.
- CHECK: latch tag/data into wb registers.
  - valid&dirty -> WB_REQ.
  - valid&!dirty -> INV.
  - !valid -> ADV.
- WB_REQ: wb_valid_o=1 with stable addr/data until wb_ready_i. On wb_valid_o&wb_ready_i -> WB_WAIT; dirty_cnt++ (saturates at 0xFFFF).
- WB_WAIT: wait for wb_done_i, then -> INV. wb_done_i outside WB_WAIT is ignored.
- INV:
  - req_o=1<<way_q, we_o=1, addr_o={set_q,0}.
  - The arbiter writes valid=0, dirty=0; tag/data byte-enables are 0.
  - Hold until gnt_i, then -> ADV.
- ADV (one cycle):
  - If way_q==SET_ASSOC-1: way_q=0, set_q++.
  - If set_q==NUM_SETS-1 and way_q==SET_ASSOC-1 -> DONE; otherwise way_q++ or wrap, then -> READ.
- DONE: flush_ack_o=1 for exactly one cycle -> IDLE.
  - If flush_i is still high in the following IDLE cycle, a new flush starts; the requester must drop flush_i on ack.
- flush_i deasserted mid-walk: ignored, the walk completes and acks.
- Grant latency is unbounded: request outputs stay stable while gnt_i=0.
- Reset mid-walk: immediate return to IDLE. No ack and no partial state retained. An outstanding writeback is the miss handler's concern.
- Worst-case latency: NUM_SETS*SET_ASSOC*(READ+CHECK+INV+ADV) cycles plus writebacks. Minimum per clean-invalid way is 3 cycles with gnt_i tied high.

Decomposition:
- std_cache_pkg: flush-state enum (IDLE, READ, CHECK, WB_REQ, WB_WAIT, INV, ADV, DONE) and the wb request struct (addr, data).
- Set and way widths derive as $clog2 of the parameters.
- No sub-module; the counters and FSM are one block.

Test Plan:
- NUM_SETS=4, SET_ASSOC=2, all lines invalid, gnt_i=1 -> 8 reads, 0 writes, 0 wb_valid_o, flush_ack_o after exactly 8*3+1 cycles from flush_i, dirty_cnt_o=0.
- Set 2 way 1: valid, dirty, tag 0x1234, data 0xA5..A5 -> wb_addr_o={0x1234,2,4'h0}, wb_data_o=0xA5..A5, one invalidate write to set 2 way 1, dirty_cnt_o=1.
- Valid clean line at set 0 way 0 -> INV write issued, no writeback.
- gnt_i held low 5 cycles in READ and INV, wb_ready_i low 3 cycles -> outputs stable throughout, no skipped way.
- flush_i dropped after 2 cycles -> walk still completes, single flush_ack_o pulse.
- rst_ni asserted in WB_WAIT -> all outputs 0 asynchronously. A new flush restarts at set 0 way 0.
